// File: rtl/arb_wrr.sv
// Weighted round-robin arbiter with burst locking; grant is combinational (0-cycle latency).
// State advances only on pop with a valid grant; the consumer applies backpressure by withholding pop.
module arb_wrr #(
  parameter int NUM_REQS = 4,
  parameter int WEIGHT_W = 4,
  localparam int IW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQS-1:0]          reqs,
  input  logic [NUM_REQS-1:0]          lock,
  input  logic [NUM_REQS*WEIGHT_W-1:0] weights,
  input  logic                         pop,
  output logic                         grant_valid,
  output logic [NUM_REQS-1:0]          grants,
  output logic [IW-1:0]                grant_idx
);

  logic [NUM_REQS-1:0][WEIGHT_W-1:0] credit_q, credit_d;
  logic [IW-1:0]                     last_q, last_d;
  logic [IW-1:0]                     owner_q, owner_d;
  logic                              locked_q, locked_d;

  logic                owner_hit;
  logic                refill;
  logic [NUM_REQS-1:0] has_credit;
  logic [NUM_REQS-1:0] elig;
  logic [IW-1:0]       win;
  logic                found;
  int                  j;
  logic [WEIGHT_W-1:0] w;

  // Winner selection: locked owner first, else rotating scan over eligible requesters
  always_comb begin
    owner_hit = locked_q && reqs[owner_q];
    for (int i = 0; i < NUM_REQS; i++) begin
      has_credit[i] = (credit_q[i] != '0);
    end
    refill = !owner_hit && ((reqs & has_credit) == '0) && (|reqs);
    elig   = refill ? reqs : (reqs & has_credit);
    win    = '0;
    found  = 1'b0;
    j      = 0;
    if (owner_hit) begin
      win   = owner_q;
      found = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQS; k++) begin
        j = int'(last_q) + k;
        if (j >= NUM_REQS) j = j - NUM_REQS;
        if (!found && elig[IW'(j)]) begin
          found = 1'b1;
          win   = IW'(j);
        end
      end
    end
    grant_valid = |reqs;
    grants      = grant_valid ? (NUM_REQS'(1) << win) : '0;
    grant_idx   = grant_valid ? win : '0;
  end

  always_comb begin
    credit_d = credit_q;
    last_d   = last_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    w        = '0;
    // An abandoned lock drops on the next edge whether or not anything is popped
    if (locked_q && !reqs[owner_q]) locked_d = 1'b0;
    if (pop && grant_valid) begin
      if (refill) begin
        for (int i = 0; i < NUM_REQS; i++) begin
          w           = weights[i*WEIGHT_W +: WEIGHT_W];
          credit_d[i] = (w == '0) ? WEIGHT_W'(1) : w;
        end
      end
      if (lock[win]) begin
        locked_d = 1'b1;
        owner_d  = win;
      end else begin
        if (credit_d[win] != '0) credit_d[win] = credit_d[win] - WEIGHT_W'(1);
        last_d   = win;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credit_q <= '0;
      last_q   <= IW'(NUM_REQS - 1);
      owner_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      credit_q <= credit_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
    end
  end

endmodule

// File: tb/tb_arb_wrr.sv
// Directed bench for arb_wrr (NUM_REQS=4, WEIGHT_W=4) with hand-computed grant sequences.
module tb_arb_wrr;

  logic        clock;
  logic        reset_n;
  logic [3:0]  reqs;
  logic [3:0]  lock;
  logic [15:0] weights;
  logic        pop;
  logic        grant_valid;
  logic [3:0]  grants;
  logic [1:0]  grant_idx;

  int n_checks = 0;
  int n_errors = 0;

  arb_wrr #(.NUM_REQS(4), .WEIGHT_W(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .reqs        (reqs),
    .lock        (lock),
    .weights     (weights),
    .pop         (pop),
    .grant_valid (grant_valid),
    .grants      (grants),
    .grant_idx   (grant_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Drive one cycle of inputs, check the combinational grant, then take the edge
  task automatic beat(input string tag, input logic [3:0] r, input logic [3:0] l,
                      input logic p, input int exp_idx);
    reqs = r;
    lock = l;
    pop  = p;
    #1;
    check({tag, "_idx"}, 32'(grant_idx), 32'(exp_idx));
    check({tag, "_vld"}, 32'(grant_valid), 32'(|r));
    cycle();
  endtask

  task automatic do_reset();
    reqs    = '0;
    lock    = '0;
    pop     = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  int eq_exp[5] = '{0, 1, 2, 3, 0};
  int wp_exp[9] = '{0, 1, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    reqs    = '0;
    lock    = '0;
    pop     = 1'b0;
    weights = 16'h1111;
    reset_n = 1'b0;
    #12;
    check("rst_grants", 32'(grants), 32'h0);
    check("rst_vld", 32'(grant_valid), 32'h0);
    check("rst_credit", 32'(dut.credit_q), 32'h0);
    check("rst_last", 32'(dut.last_q), 32'h3);
    check("rst_locked", 32'(dut.locked_q), 32'h0);
    reqs = 4'b0110;
    #1;
    check("rst_comb_grants", 32'(grants), 32'h2);
    check("rst_comb_idx", 32'(grant_idx), 32'h1);
    reqs = '0;
    @(negedge clock);
    reset_n = 1'b1;

    // Equal weights
    weights = 16'h1111;
    for (int i = 0; i < 5; i++) beat($sformatf("eq%0d", i), 4'b1111, 4'b0000, 1'b1, eq_exp[i]);

    // Weighted pair w0=3, w1=1
    do_reset();
    weights = 16'h1113;
    for (int i = 0; i < 9; i++) beat($sformatf("wp%0d", i), 4'b0011, 4'b0000, 1'b1, wp_exp[i]);

    // Burst lock on requester 2
    do_reset();
    weights = 16'h1111;
    beat("bl1", 4'b0101, 4'b0000, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("bl_lock%0d", i), 4'b0101, 4'b0100, 1'b1, 2);
      check($sformatf("bl_credit2_%0d", i), 32'(dut.credit_q[2]), 32'h1);
      check($sformatf("bl_locked_%0d", i), 32'(dut.locked_q), 32'h1);
    end
    beat("bl_final", 4'b0101, 4'b0000, 1'b1, 2);
    check("bl_credit2_end", 32'(dut.credit_q[2]), 32'h0);
    check("bl_unlocked", 32'(dut.locked_q), 32'h0);
    beat("bl_refill", 4'b0101, 4'b0000, 1'b1, 0);

    // Owner withdrawal
    do_reset();
    weights = 16'h1111;
    beat("ow1", 4'b0110, 4'b0000, 1'b1, 1);
    beat("ow_lock", 4'b0110, 4'b0100, 1'b1, 2);
    check("ow_locked", 32'(dut.locked_q), 32'h1);
    reqs = 4'b0010;
    lock = 4'b0000;
    pop  = 1'b0;
    #1;
    check("ow_same_cycle_idx", 32'(grant_idx), 32'h1);
    check("ow_grants", 32'(grants), 32'h2);
    cycle();
    check("ow_locked_clr", 32'(dut.locked_q), 32'h0);
    check("ow_credit2", 32'(dut.credit_q[2]), 32'h1);

    // Zero weight and idle pop
    do_reset();
    weights = 16'h0111;
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("zw%0d", i), 4'b1000, 4'b0000, 1'b1, 3);
      check($sformatf("zw_credit%0d", i), 32'(dut.credit_q), 32'h0111);
    end
    reqs = 4'b0000;
    pop  = 1'b1;
    #1;
    check("idle_grants", 32'(grants), 32'h0);
    check("idle_vld", 32'(grant_valid), 32'h0);
    check("idle_idx", 32'(grant_idx), 32'h0);
    cycle();
    check("idle_credit", 32'(dut.credit_q), 32'h0111);
    check("idle_last", 32'(dut.last_q), 32'h3);
    check("idle_locked", 32'(dut.locked_q), 32'h0);

    // Asynchronous reset mid-burst
    do_reset();
    weights = 16'h1111;
    beat("ar0", 4'b1111, 4'b0000, 1'b1, 0);
    beat("ar1", 4'b1111, 4'b0000, 1'b1, 1);
    beat("ar2", 4'b1111, 4'b0000, 1'b1, 2);
    beat("ar_lock", 4'b1111, 4'b1000, 1'b1, 3);
    check("ar_locked", 32'(dut.locked_q), 32'h1);
    check("ar_owner", 32'(dut.owner_q), 32'h3);
    pop = 1'b0;
    lock = 4'b0000;
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_locked_async", 32'(dut.locked_q), 32'h0);
    check("ar_credit_async", 32'(dut.credit_q), 32'h0);
    reset_n = 1'b1;
    #1;
    check("ar_first_idx", 32'(grant_idx), 32'h0);
    @(negedge clock);
    beat("ar_post", 4'b1111, 4'b0000, 1'b1, 0);
    beat("ar_post2", 4'b1111, 4'b0000, 1'b1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arb_wrr.md
# arb_wrr

Parametrised weighted round-robin arbiter with burst locking, the successor to the plain round-robin arbiter used on shared-resource request paths in the core and its memory/bus front-ends. Each requester receives a programmable number of grant units per round. A requester may lock the grant across a multi-beat burst. Grant is combinational from the current requests and registered state; state advances only on an accepted grant (`pop`).

## Interface
- `NUM_REQS`, default 4: number of requesters, 1 or more.
- `WEIGHT_W`, default 4: width of each weight and credit counter.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `reqs` in NUM_REQS: request vector, bit i for requester i.
- `lock` in NUM_REQS: bit i high means requester i wants to keep the grant after the current beat.
- `weights` in NUM_REQS*WEIGHT_W: per-requester weight; requester i uses `[i*WEIGHT_W +: WEIGHT_W]`. Sampled only at refill.
- `pop` in 1: consumer accepts the current grant this cycle.
- `grant_valid` out 1: a grant is presented, equal to `|reqs`.
- `grants` out NUM_REQS: one-hot winner; all zero when `grant_valid` is 0.
- `grant_idx` out clog2(NUM_REQS), min 1: binary index of the winner; 0 when `grant_valid` is 0.

## Operation
**State**
- `credit[i]`: WEIGHT_W bits per requester.
- `last`: index of the last burst-final winner.
- `locked` (1 bit) and `owner` (index).

**Effective weight:** `weff[i] = (weights[i]==0) ? 1 : weights[i]`.

**Winner selection**, evaluated combinationally every cycle:
1. If `locked` and `reqs[owner]`, the winner is `owner`.
2. Otherwise, let `elig = reqs & (credit != 0)`.
3. If `elig` is 0 and `reqs` is non-zero, this is a refill cycle, and `elig = reqs`.
4. The winner is the first set bit of `elig` scanning upward from `last+1`, wrapping modulo NUM_REQS.

**Update on `pop && grant_valid`** (a `pop` with `grant_valid`=0 is ignored and changes no state):
- Refill cycle: every `credit[i]` is set to `weff[i]`, then the winner's decrement below applies on top.
- `lock[winner]`=1: set `locked`=1 and `owner`=winner. No credit is consumed and `last` is unchanged.
- `lock[winner]`=0, i.e. the final beat: decrement `credit[winner]` (never below 0), set `last`=winner, clear `locked`.

**Lock abandonment:** if `locked` and `reqs[owner]`=0, selection falls through to steps 2–4 in the same cycle. `locked` clears on the next edge regardless of `pop`. The owner's credit is not decremented.

**Weight changes:** a change to `weights` takes effect only at the next refill.

**NUM_REQS==1:** `grants = reqs`, `grant_idx = 0`. The lock and credit logic is present but does not affect the outcome.

**Reset values** (`reset_n` low):
- `credit[i]=0`, so the first arbitration is a refill.
- `last = NUM_REQS-1`, so requester 0 has first priority.
- `locked=0`, `owner=0`.

**Outputs during reset:** outputs stay combinational on `reqs` with this reset state, e.g. `reqs=0110` gives `grants=0010`.

## Timing
- Grant latency: 0 cycles from `reqs`. No registered output path.
- State update: one edge after `pop`. A new winner is visible in the cycle after `pop`.
- Throughput: one grant per cycle with `pop` held high.
- Refill and decrement occur on the same edge; no bubble cycle.
- Reset mid-burst: `locked` is dropped and credits cleared immediately (asynchronous). After `reset_n` rises, the first grant goes to the lowest-index active request.
- Simultaneous lock release and owner withdrawal: withdrawal wins. No credit is consumed and `last` is unchanged.

## Test plan
All scenarios use NUM_REQS=4 and WEIGHT_W=4.
- **Equal weights:** weights all 1, `reqs=1111`, `pop` held 1 for 5 cycles → `grant_idx` sequence 0,1,2,3,0; `grant_valid`=1 throughout.
- **Weighted pair:** w0=3, w1=1, `reqs=0011`, continuous `pop` → `grant_idx` 0,1,0,0,1,0,0,0,1.
- **Burst lock:** weights 1, `reqs=0101`.
  - Pop 1 → idx 0.
  - Pops 2–4 with `lock[2]`=1 → idx stays 2, `credit[2]` stays 1.
  - Pop 5 with `lock[2]`=0 → idx 2, then next grant idx 0 via refill.
- **Owner withdrawal:** locked on requester 2, `reqs` drops from 0110 to 0010 → `grant_idx`=1 in the same cycle, `locked`=0 after the next edge, `credit[2]` unchanged.
- **Zero weight and idle pop:** w3=0, `reqs=1000`, pops → every grant idx 3, a refill on each pop. `pop` with `reqs=0000` → `grants=0000`, state unchanged.
- **Asynchronous reset mid-burst:**
  - Setup: locked on requester 3 with credits partially consumed.
  - Stimulus: pulse `reset_n` low between edges.
  - Required: `locked` clears immediately. With `reqs=1111` after release, the first grant idx is 0.
